// File: rtl/apb_uart.sv
// APB slave UART: one 8N1 transmitter, one 8N1 receiver, programmable baud divisor and a
// level interrupt. Zero-wait-state; all serial timing is derived from clk.
module apb_uart #(
    parameter logic [15:0] DEFAULT_DIV = 16'd867,
    parameter logic [15:0] MIN_DIV     = 16'd3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] io_paddr,
    input  logic        io_pwrite,
    input  logic        io_psel,
    input  logic        io_penable,
    input  logic [31:0] io_pwdata,
    output logic [31:0] io_prdata,
    output logic        io_pready,
    output logic        io_pslverr,
    output logic        io_txd,
    input  logic        io_rxd,
    output logic        io_irq
);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    logic        access, addr_ok, wr, rd, tx_busy, wr_data, rd_data, wr_status;
    logic [1:0]  reg_sel;
    logic [15:0] div_q;
    logic        rx_irq_en_q, irq_q;
    logic        rx_valid_q, rx_overrun_q, rx_frame_err_q;
    logic [7:0]  rx_data_q;

    state_e      tx_state_q, tx_state_d;
    logic [15:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]  tx_bit_q, tx_bit_d;
    logic [7:0]  tx_byte_q;
    logic        txd_q, txd_d, tx_tick;

    state_e      rx_state_q, rx_state_d;
    logic [15:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]  rx_bit_q, rx_bit_d;
    logic [7:0]  rx_shift_q, rx_shift_d;
    logic        rxd_meta_q, rxd_sync_q, rxd_prev_q, rx_fall, rx_tick, rx_done;

    logic        unused_bits;
    assign unused_bits = ^{io_paddr[31:12], io_paddr[1:0], io_pwdata[31:16]};

    // APB decode
    assign access    = io_psel & io_penable;
    assign addr_ok   = (io_paddr[11:4] == 8'd0);
    assign reg_sel   = io_paddr[3:2];
    assign wr        = access & io_pwrite & addr_ok;
    assign rd        = access & ~io_pwrite & addr_ok;
    assign tx_busy   = (tx_state_q != StIdle);
    assign wr_data   = wr & (reg_sel == 2'd0) & ~tx_busy;
    assign rd_data   = rd & (reg_sel == 2'd0);
    assign wr_status = wr & (reg_sel == 2'd1);

    assign io_pready  = 1'b1;
    assign io_pslverr = access & (~addr_ok | (io_pwrite & (reg_sel == 2'd0) & tx_busy));
    assign io_txd     = txd_q;
    assign io_irq     = irq_q;

    always_comb begin
        io_prdata = 32'd0;
        if (rd) begin
            case (reg_sel)
                2'd0:    io_prdata = {24'd0, rx_data_q};
                2'd1:    io_prdata = {28'd0, rx_frame_err_q, rx_overrun_q, rx_valid_q, tx_busy};
                2'd2:    io_prdata = {16'd0, div_q};
                default: io_prdata = {31'd0, rx_irq_en_q};
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_q       <= DEFAULT_DIV;
            rx_irq_en_q <= 1'b0;
            irq_q       <= 1'b0;
        end else begin
            if (wr && reg_sel == 2'd2) begin
                div_q <= (io_pwdata[15:0] < MIN_DIV) ? MIN_DIV : io_pwdata[15:0];
            end
            if (wr && reg_sel == 2'd3) begin
                rx_irq_en_q <= io_pwdata[0];
            end
            irq_q <= rx_irq_en_q & (rx_valid_q | rx_overrun_q | rx_frame_err_q);
        end
    end

    // Delivery beats a coinciding DATA read, so that case is not an overrun.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_data_q      <= 8'd0;
            rx_valid_q     <= 1'b0;
            rx_overrun_q   <= 1'b0;
            rx_frame_err_q <= 1'b0;
        end else begin
            if (rx_done) begin
                if (rx_valid_q && !rd_data) begin
                    rx_overrun_q <= 1'b1;
                end else begin
                    rx_data_q  <= rx_shift_q;
                    rx_valid_q <= 1'b1;
                end
            end else if (rd_data) begin
                rx_valid_q <= 1'b0;
            end
            if (!(rx_done && rx_valid_q && !rd_data) && wr_status && io_pwdata[2]) begin
                rx_overrun_q <= 1'b0;
            end
            if (rx_done && !rxd_sync_q) begin
                rx_frame_err_q <= 1'b1;
            end else if (wr_status && io_pwdata[3]) begin
                rx_frame_err_q <= 1'b0;
            end
        end
    end

    // Transmitter
    assign tx_tick = (tx_cnt_q == 16'd0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_state_q <= StIdle;
            tx_cnt_q   <= 16'd0;
            tx_bit_q   <= 3'd0;
            tx_byte_q  <= 8'd0;
            txd_q      <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            txd_q      <= txd_d;
            if (wr_data) begin
                tx_byte_q <= io_pwdata[7:0];
            end
        end
    end

    always_comb begin
        tx_state_d = tx_state_q;
        case (tx_state_q)
            StIdle:  if (wr_data) tx_state_d = StStart;
            StStart: if (tx_tick) tx_state_d = StData;
            StData:  if (tx_tick && tx_bit_q == 3'd7) tx_state_d = StStop;
            default: if (tx_tick) tx_state_d = StIdle;
        endcase
    end

    // Down-counter reloads from div_q at every bit boundary.
    always_comb begin
        tx_cnt_d = tx_cnt_q - 16'd1;
        tx_bit_d = tx_bit_q;
        if (tx_state_q == StIdle) begin
            tx_cnt_d = div_q;
            tx_bit_d = 3'd0;
        end else if (tx_tick) begin
            tx_cnt_d = div_q;
            if (tx_state_q == StData) begin
                tx_bit_d = tx_bit_q + 3'd1;
            end
        end
        case (tx_state_d)
            StStart: txd_d = 1'b0;
            StData:  txd_d = tx_byte_q[tx_bit_d];
            default: txd_d = 1'b1;
        endcase
    end

    // Receiver
    assign rx_fall = rxd_prev_q & ~rxd_sync_q;
    assign rx_tick = (rx_cnt_q == 16'd0);
    assign rx_done = (rx_state_q == StStop) & rx_tick;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rxd_meta_q <= 1'b1;
            rxd_sync_q <= 1'b1;
            rxd_prev_q <= 1'b1;
            rx_state_q <= StIdle;
            rx_cnt_q   <= 16'd0;
            rx_bit_q   <= 3'd0;
            rx_shift_q <= 8'd0;
        end else begin
            rxd_meta_q <= io_rxd;
            rxd_sync_q <= rxd_meta_q;
            rxd_prev_q <= rxd_sync_q;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
        end
    end

    always_comb begin
        rx_state_d = rx_state_q;
        case (rx_state_q)
            StIdle:  if (rx_fall) rx_state_d = StStart;
            StStart: if (rx_tick) rx_state_d = rxd_sync_q ? StIdle : StData;
            StData:  if (rx_tick && rx_bit_q == 3'd7) rx_state_d = StStop;
            default: if (rx_tick) rx_state_d = StIdle;
        endcase
    end

    // Idle preloads the half-period so the start bit is checked mid-bit.
    always_comb begin
        rx_cnt_d   = rx_cnt_q - 16'd1;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        if (rx_state_q == StIdle) begin
            rx_cnt_d = {1'b0, div_q[15:1]};
            rx_bit_d = 3'd0;
        end else if (rx_tick) begin
            rx_cnt_d = div_q;
            if (rx_state_q == StData) begin
                rx_shift_d = {rxd_sync_q, rx_shift_q[7:1]};
                rx_bit_d   = rx_bit_q + 3'd1;
            end
        end
    end

endmodule

// File: tb/tb_apb_uart.sv
// Directed bench for apb_uart: reset, TX framing/busy error, RX delivery, overrun,
// frame error, false-start rejection and address decode.
module tb_apb_uart;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] paddr, pwdata, prdata;
    logic        pwrite, psel, penable, pready, pslverr, txd, rxd, irq;

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] ADDR_DATA = 32'h0, ADDR_STATUS = 32'h4;
    localparam logic [31:0] ADDR_DIV = 32'h8, ADDR_CTRL = 32'hC;

    apb_uart dut (
        .clk        (clk),
        .reset      (reset),
        .io_paddr   (paddr),
        .io_pwrite  (pwrite),
        .io_psel    (psel),
        .io_penable (penable),
        .io_pwdata  (pwdata),
        .io_prdata  (prdata),
        .io_pready  (pready),
        .io_pslverr (pslverr),
        .io_txd     (txd),
        .io_rxd     (rxd),
        .io_irq     (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic apb_xfer(input logic [31:0] addr, input logic write, input logic [31:0] data,
                            output logic [31:0] rdata, output logic err);
        @(negedge clk);
        psel = 1'b1; penable = 1'b0; pwrite = write; paddr = addr; pwdata = data;
        @(negedge clk);
        penable = 1'b1;
        #1;
        rdata = prdata;
        err   = pslverr;
        @(posedge clk);
        #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic wr(input string tag, input logic [31:0] addr, input logic [31:0] data);
        logic [31:0] d;
        logic        e;
        apb_xfer(addr, 1'b1, data, d, e);
        check({tag, "_err"}, 32'(e), 32'd0);
    endtask

    task automatic rd_chk(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        logic [31:0] d;
        logic        e;
        apb_xfer(addr, 1'b0, 32'd0, d, e);
        check(tag, d, exp);
        check({tag, "_err"}, 32'(e), 32'd0);
    endtask

    // One 8N1 frame at 8 clk cycles per bit.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        @(negedge clk);
        rxd = 1'b0;
        repeat (8) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (8) @(negedge clk);
        end
        rxd = stop_bit;
        repeat (8) @(negedge clk);
        rxd = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] d;
        logic        e, exp_txd;
        logic [7:0]  tx_byte;

        reset = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = 32'd0; pwdata = 32'd0; rxd = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_txd", 32'(txd), 32'd1);
        check("rst_irq", 32'(irq), 32'd0);
        check("rst_pslverr", 32'(pslverr), 32'd0);
        check("rst_prdata", prdata, 32'd0);
        check("pready", 32'(pready), 32'd1);
        reset = 1'b0;

        // Reset in the middle of a start bit at the default divisor
        wr("tx_default", ADDR_DATA, 32'h00);
        repeat (20) @(negedge clk);
        check("txd_before_reset", 32'(txd), 32'd0);
        #2 reset = 1'b1;
        #1;
        check("txd_async_reset", 32'(txd), 32'd1);
        check("irq_async_reset", 32'(irq), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        rd_chk("status_after_reset", ADDR_STATUS, 32'h0);
        rd_chk("div_after_reset", ADDR_DIV, 32'd867);
        rd_chk("ctrl_after_reset", ADDR_CTRL, 32'd0);

        // TX 0xA5 at DIV=3, with a rejected second write 10 cycles in
        wr("div3", ADDR_DIV, 32'd3);
        tx_byte = 8'hA5;
        apb_xfer(ADDR_DATA, 1'b1, 32'hA5, d, e);
        check("tx_write_err", 32'(e), 32'd0);
        psel = 1'b1; penable = 1'b1; pwrite = 1'b0; paddr = ADDR_STATUS;
        for (int k = 0; k < 48; k++) begin
            @(negedge clk);
            if (k == 10) check("tx_busy_pslverr", 32'(pslverr), 32'd1);
            else check($sformatf("tx_busy[%0d]", k), 32'(prdata[0]), 32'(k < 40));
            if (k < 4) exp_txd = 1'b0;
            else if (k < 36) exp_txd = tx_byte[(k - 4) / 4];
            else exp_txd = 1'b1;
            check($sformatf("txd[%0d]", k), 32'(txd), 32'(exp_txd));
            if (k == 9) begin
                pwrite = 1'b1; paddr = ADDR_DATA; pwdata = 32'h3C;
            end
            if (k == 10) begin
                pwrite = 1'b0; paddr = ADDR_STATUS;
            end
        end
        psel = 1'b0; penable = 1'b0;
        rd_chk("status_after_tx", ADDR_STATUS, 32'h0);

        // RX 0x5A at DIV=7 with interrupt enabled
        wr("div7", ADDR_DIV, 32'd7);
        wr("ctrl1", ADDR_CTRL, 32'd1);
        rd_chk("ctrl_read", ADDR_CTRL, 32'd1);
        send_frame(8'h5A, 1'b1);
        check("rx_irq_set", 32'(irq), 32'd1);
        rd_chk("rx_status", ADDR_STATUS, 32'h2);
        rd_chk("rx_data", ADDR_DATA, 32'h5A);
        repeat (2) @(negedge clk);
        check("rx_irq_clear", 32'(irq), 32'd0);
        rd_chk("rx_status_clear", ADDR_STATUS, 32'h0);

        // Overrun: second frame dropped, first byte kept
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        rd_chk("ovr_status", ADDR_STATUS, 32'h6);
        rd_chk("ovr_data", ADDR_DATA, 32'h11);
        rd_chk("ovr_status2", ADDR_STATUS, 32'h4);

        // Frame error: byte still delivered
        send_frame(8'h33, 1'b0);
        rd_chk("ferr_status", ADDR_STATUS, 32'hE);
        wr("status_clear", ADDR_STATUS, 32'hC);
        rd_chk("status_errs_cleared", ADDR_STATUS, 32'h2);
        rd_chk("ferr_data", ADDR_DATA, 32'h33);
        rd_chk("status_empty", ADDR_STATUS, 32'h0);
        check("irq_idle", 32'(irq), 32'd0);

        // False start, then a clean frame
        @(negedge clk);
        rxd = 1'b0;
        repeat (2) @(negedge clk);
        rxd = 1'b1;
        repeat (30) @(negedge clk);
        rd_chk("glitch_status", ADDR_STATUS, 32'h0);
        send_frame(8'h96, 1'b1);
        rd_chk("after_glitch_data", ADDR_DATA, 32'h96);

        // Divisor clamp and address decode
        wr("div1", ADDR_DIV, 32'd1);
        rd_chk("div_clamped", ADDR_DIV, 32'd3);
        apb_xfer(32'h10, 1'b0, 32'd0, d, e);
        check("bad_addr_rd_err", 32'(e), 32'd1);
        check("bad_addr_rd_data", d, 32'd0);
        apb_xfer(32'h18, 1'b1, 32'h55, d, e);
        check("bad_addr_wr_err", 32'(e), 32'd1);
        rd_chk("div_unchanged", ADDR_DIV, 32'd3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/apb_uart.md
Name: apb_uart

Overview:
- APB slave UART that sits downstream of the 4-slave APB bus decoder, on the uart slot (paddr[31:24] = 0xF1).
- Provides one 8N1 transmitter, one 8N1 receiver, a programmable baud divisor and a level interrupt.
- Zero-wait-state APB slave; all serial timing is derived from clk.

Parameters:
- DEFAULT_DIV, 16'd867: reset value of the divisor register. One bit period = DIV+1 clk cycles (115200 baud at 100 MHz).
- MIN_DIV, 16'd3: smallest divisor stored. Writes below it are clamped to it.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- io_paddr  in  32  APB address; paddr[3:2] selects the register, paddr[11:4] must be 0
- io_pwrite  in  1  APB write
- io_psel  in  1  APB select
- io_penable  in  1  APB access phase
- io_pwdata  in  32  APB write data
- io_prdata  out  32  APB read data
- io_pready  out  1  APB ready, constant 1
- io_pslverr  out  1  APB error
- io_txd  out  1  serial transmit line, idle high
- io_rxd  in  1  serial receive line, asynchronous to clk
- io_irq  out  1  interrupt, level high

Behaviour:
- Reset values: io_txd=1, io_irq=0, io_pslverr=0, io_prdata=0. DIV=DEFAULT_DIV, CTRL=0, all status bits 0, both FSMs in IDLE.
- An access completes when psel & penable; pready is always 1. A write commits on the clk edge that ends the access phase. prdata is combinational and driven 0 when not (psel & penable).
- Register map, offsets paddr[3:0]:
  - 0x0 DATA
    - Write: loads tx_shift[7:0] and starts TX. pslverr=1 and write ignored if tx_busy.
    - Read: returns {24'b0, rx_data}. If rx_valid, clears rx_valid on that edge.
  - 0x4 STATUS: bit0 tx_busy, bit1 rx_valid, bit2 rx_overrun, bit3 rx_frame_err. Writing 1 to bit2 or bit3 clears that bit; writes to other bits are ignored.
  - 0x8 DIV: bits [15:0]. Stored value = max(pwdata[15:0], MIN_DIV). Reads return the stored value.
  - 0xC CTRL: bit0 rx_irq_en. Other bits read 0.
  - Any access with paddr[11:4] != 0: pslverr=1, writes have no effect, reads return 0.
- io_irq = rx_irq_en & (rx_valid | rx_overrun | rx_frame_err), registered (1-cycle lag).
- Bit timer: a counter counts 0..DIV, then wraps. A DIV write takes effect at the next bit boundary of each FSM.
- TX FSM: IDLE -> START -> DATA -> STOP -> IDLE.
  - START drives 0 for DIV+1 cycles.
  - DATA sends 8 bits LSB first, DIV+1 cycles each.
  - STOP drives 1 for DIV+1 cycles.
  - tx_busy = state != IDLE. It goes high on the edge after the DATA write.
  - io_txd is registered; the start bit appears on the cycle after the write commits.
  - A new DATA write is accepted on the cycle after STOP ends.
- RX front end: io_rxd passes through a 2-flop synchronizer (reset to 1), then an edge detector.
- RX FSM: IDLE -> START -> DATA -> STOP.
  - IDLE: a falling edge on the synchronized line enters START and loads the half-period count (DIV>>1).
  - START: at the half-period, if the line is 1 (false start) return to IDLE; else wait DIV+1 cycles per sample.
  - DATA: sample 8 bits at mid-bit, LSB first.
  - STOP: sample the stop bit at mid-bit.
    - If the stop bit is 0, set rx_frame_err; the byte is still delivered.
    - If rx_valid is already 1: set rx_overrun; rx_data keeps the old byte and the new byte is dropped.
    - Otherwise: rx_data = byte, rx_valid = 1.
    - Return to IDLE immediately after the stop-bit sample, so back-to-back frames are caught.
- A DATA read that coincides with byte delivery: the delivery wins (rx_valid stays 1 with the new byte), and the read returns the old byte.
- reset asserted mid-frame: io_txd=1 immediately (asynchronous), both FSMs return to IDLE, registers return to reset values.

Test Plan:
- Reset: assert reset mid-TX -> io_txd=1 and io_irq=0 at once. After release, STATUS reads 0x0 and DIV reads 867.
- TX: DIV=3, write DATA=0xA5 -> txd low from the cycle after the write for 4 cycles, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then high 4 cycles. STATUS bit0 = 1 for exactly 40 cycles.
- TX busy error: second DATA write (0x3C) 10 cycles after the first -> pslverr=1, and the serial output carries only 0xA5.
- RX: DIV=7, CTRL=1, drive frame 0x5A at 8 cycles/bit -> STATUS=0x2 and irq=1. DATA read returns 0x5A, then STATUS=0x0 and irq drops within 2 cycles.
- RX errors:
  - Two frames 0x11 then 0x22 with no read -> DATA=0x11 and STATUS bit2=1.
  - Frame with stop bit 0 -> STATUS bit3=1.
  - Write STATUS=0xC -> both error bits clear.
- Glitch and decode:
  - 2-cycle low pulse on rxd with DIV=7 -> no byte delivered.
  - Write DIV=1 -> reads back 3.
  - Read at offset 0x10 -> pslverr=1, prdata=0.
